slv_arbiter: RTL
================

Name: slv_arbiter

Overview:
- Three-input arbiter that sits directly downstream of the three channel slave FIFOs.
- Consumes each slave's slvx_val/slvx_dat stream and returns the per-slave a2sX_ack.
- Grants one slave at a time in bursts, using programmable priority with round-robin tie-break.
- Presents the selected words, tagged with source ID, to the formatter through a registered valid/ack output stage.

Parameters:
- DW, 32, data width of slave and output words
- MAX_BURST, 8, maximum words taken from one slave per grant (1..16)

Ports:
- clk_i  input  1  clock
- rst_i  input  1  synchronous active-high reset
- slv0_val_i  input  1  slave 0 has data (head word valid)
- slv0_dat_i  input  DW  slave 0 head word
- slv0_prio_i  input  2  slave 0 priority, 0 = highest
- a2s0_ack_o  output  1  pop slave 0 head word this cycle
- slv1_val_i, slv1_dat_i, slv1_prio_i, a2s1_ack_o  as above, slave 1
- slv2_val_i, slv2_dat_i, slv2_prio_i, a2s2_ack_o  as above, slave 2
- arb_val_o  output  1  output word valid
- arb_dat_o  output  DW  output word
- arb_id_o  output  2  source slave of arb_dat_o (0..2)
- f2a_ack_i  input  1  formatter accepts arb_dat_o this cycle

Behaviour:
- Clocking and reset:
  - Single clock; reset is synchronous and active-high.
  - All state updates on posedge clk_i.
  - rst_i high at a posedge clears: arb_val_o=0, arb_dat_o=0, arb_id_o=0, state=IDLE, burst count=0, rr pointer=2 (slave 0 is first in round-robin order).
  - a2sX_ack_o are 0 while rst_i is high.
- Slave transfer rule:
  - A word leaves slave X on any cycle where slvX_val_i && a2sX_ack_o.
  - a2sX_ack_o is 1 only for the granted slave, and only when state=GRANT && slvX_val_i && (!arb_val_o || f2a_ack_i).
  - At most one a2sX_ack_o is high per cycle.
  - The acked word is captured into arb_dat_o/arb_id_o at that posedge, and arb_val_o is set to 1.
- Output stage:
  - arb_val_o falls only when f2a_ack_i=1 and no new word is captured in the same cycle.
  - arb_dat_o and arb_id_o are held stable while arb_val_o && !f2a_ack_i.
  - Throughput is 1 word/cycle while f2a_ack_i stays high.
  - Latency is 1 cycle from slave pop to arb_val_o.
- State machine:
  - IDLE: if any slvX_val_i=1, select a winner and go to GRANT with grant=winner and burst count=0.
  - Winner selection: the requester with the lowest prio value. Ties go to the first requester after the rr pointer in order 0→1→2→0.
  - GRANT: burst count increments on each pop.
  - GRANT exits to IDLE when:
    - the popped word is burst number MAX_BURST, or
    - slvX_val_i of the granted slave is 0 at a posedge (slave empty).
  - On GRANT→IDLE the rr pointer is set to the released slave.
  - IDLE always lasts exactly 1 cycle before a new grant. This gives a 1-cycle bubble between grants, which is intended.
- Prio inputs are sampled only in IDLE; changes during GRANT have no effect until the next arbitration.
- A slave deasserting val mid-burst ends the grant; its partial burst is not resumed.
- Backpressure during GRANT (f2a_ack_i=0 with arb_val_o=1) stalls pops and does not consume burst count or end the grant.
- rst_i mid-burst: aborts the burst, discards any word in the output register, and deasserts every ack in the same cycle. No further pops occur until a new IDLE→GRANT.
- X/Z on slvX_dat_i while slvX_val_i=0 must never reach arb_dat_o.

Test Plan:
- Reset, then slave 0 only with 3 words 0x1,0x2,0x3, equal prio, f2a_ack_i=1:
  - arb_val_o asserts 2 cycles after val (IDLE, GRANT).
  - Output 0x1,0x2,0x3 on consecutive cycles with arb_id_o=0; a2s0_ack_o high for 3 cycles.
  - After the last word, the grant releases on the empty val.
- All three slaves continuously valid, all prio=1, MAX_BURST=8, f2a_ack_i=1:
  - Grant order 0,1,2,0; exactly 8 words per grant.
  - One bubble cycle between bursts; no ack overlap.
- Slave 0 prio=2, slave 2 prio=0, both valid:
  - Slave 2 is granted first.
  - After its burst, slave 2 is re-granted if it is still valid, since it has the lower prio value.
- f2a_ack_i held 0 for 5 cycles mid-burst with word 0x0000_0014 in the output:
  - arb_dat_o stays 0x14 and all acks stay 0.
  - The burst count is unchanged.
  - The stream resumes with no loss or duplication when f2a_ack_i returns to 1.
- Slave 1 val drops after 3 of 8 words while slave 2 is waiting:
  - Slave 1 is released.
  - Slave 2 is granted after a 1-cycle IDLE.
  - Slave 1's remaining words wait for the next round.
- rst_i pulsed for 1 cycle during a burst:
  - The next cycle shows arb_val_o=0 and all acks 0.
  - Arbitration restarts from slave 0 when val is present.

Source files
------------

// File: rtl/slv_arbiter.sv
// Three-slave burst arbiter: lowest prio value wins, round-robin tie-break,
// registered valid/ack output stage tagged with the source slave ID.
module slv_arbiter #(
    parameter int DW        = 32,
    parameter int MAX_BURST = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          slv0_val_i,
    input  logic [DW-1:0] slv0_dat_i,
    input  logic [1:0]    slv0_prio_i,
    output logic          a2s0_ack_o,
    input  logic          slv1_val_i,
    input  logic [DW-1:0] slv1_dat_i,
    input  logic [1:0]    slv1_prio_i,
    output logic          a2s1_ack_o,
    input  logic          slv2_val_i,
    input  logic [DW-1:0] slv2_dat_i,
    input  logic [1:0]    slv2_prio_i,
    output logic          a2s2_ack_o,
    output logic          arb_val_o,
    output logic [DW-1:0] arb_dat_o,
    output logic [1:0]    arb_id_o,
    input  logic          f2a_ack_i
);

    localparam int CW = 5;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state;
    logic [1:0]      grant;
    logic [1:0]      rr;
    logic [CW-1:0]   cnt;

    logic [2:0]      val;
    logic [2:0][1:0] prio;
    logic [1:0]      win;
    logic [1:0]      best;
    logic [1:0]      idx;
    logic            found;
    logic            gval;
    logic [DW-1:0]   gdat;
    logic            pop;

    assign val  = {slv2_val_i, slv1_val_i, slv0_val_i};
    assign prio = {slv2_prio_i, slv1_prio_i, slv0_prio_i};

    // Scan in round-robin order after rr; strict '<' keeps the earliest tie.
    always_comb begin
        win   = 2'd0;
        best  = 2'd3;
        found = 1'b0;
        idx   = 2'd0;
        for (int k = 1; k <= 3; k++) begin
            idx = 2'((int'(rr) + k) % 3);
            if (val[idx] && (!found || prio[idx] < best)) begin
                found = 1'b1;
                best  = prio[idx];
                win   = idx;
            end
        end
    end

    always_comb begin
        gval = 1'b0;
        gdat = slv0_dat_i;
        case (grant)
            2'd0: begin gval = slv0_val_i; gdat = slv0_dat_i; end
            2'd1: begin gval = slv1_val_i; gdat = slv1_dat_i; end
            2'd2: begin gval = slv2_val_i; gdat = slv2_dat_i; end
            default: begin gval = 1'b0; gdat = slv0_dat_i; end
        endcase
    end

    assign pop        = !rst_i && (state == GRANT) && gval && (!arb_val_o || f2a_ack_i);
    assign a2s0_ack_o = pop && (grant == 2'd0);
    assign a2s1_ack_o = pop && (grant == 2'd1);
    assign a2s2_ack_o = pop && (grant == 2'd2);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            grant     <= 2'd0;
            rr        <= 2'd2;
            cnt       <= '0;
            arb_val_o <= 1'b0;
            arb_dat_o <= '0;
            arb_id_o  <= 2'd0;
        end else begin
            if (pop) begin
                arb_val_o <= 1'b1;
                arb_dat_o <= gdat;
                arb_id_o  <= grant;
            end else if (f2a_ack_i) begin
                arb_val_o <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (|val) begin
                        state <= GRANT;
                        grant <= win;
                        cnt   <= '0;
                    end
                end
                GRANT: begin
                    if (!gval) begin
                        state <= IDLE;
                        rr    <= grant;
                    end else if (pop) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(MAX_BURST - 1)) begin
                            state <= IDLE;
                            rr    <= grant;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
